// File: rtl/spi_master.sv
// SPI mode-0 master: one byte per request, MSB first, with optional chip-select hold
// between bytes and a guaranteed minimum deselect time before returning to idle.
module spi_master #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       hold_cs,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       spi_sclk,
   output logic       spi_cs_n,
   output logic       spi_mosi,
   input  logic       spi_miso
);

   typedef enum logic [1:0] {IDLE, XFER, HOLD, DESEL} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t     state, state_nxt;
   logic       ready_en;
   logic [7:0] div_cnt;
   logic [2:0] bit_cnt;
   logic [6:0] tx_shift;   // bits still to send after the one on spi_mosi
   logic [6:0] rx_shift;   // bits received so far; the 8th goes straight to rx_data
   logic [1:0] miso_sync;
   logic       div_end;
   logic       accept;
   logic       byte_end;

   assign div_end  = (div_cnt == DIV_LAST);
   assign tx_ready = ready_en && ((state == IDLE) || (state == HOLD));
   assign accept   = tx_valid && tx_ready;
   assign byte_end = (state == XFER) && div_end && spi_sclk && (bit_cnt == 3'd0);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Every byte ends in HOLD for at least one cycle: that is the rx_valid cycle in which
   // hold_cs is sampled, and a pending request there wins over a falling hold_cs.
   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = XFER;
         XFER:    if (byte_end) state_nxt = HOLD;
         HOLD: begin
            if (accept)        state_nxt = XFER;
            else if (!hold_cs) state_nxt = DESEL;
         end
         DESEL:   if (div_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en  <= 1'b0;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         tx_shift  <= '0;
         rx_shift  <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         spi_sclk  <= 1'b0;
         spi_cs_n  <= 1'b1;
         spi_mosi  <= 1'b0;
         miso_sync <= '0;
      end else begin
         // NOTE: non-blocking throughout so every flop samples pre-edge values.
         ready_en  <= 1'b1;
         miso_sync <= {miso_sync[0], spi_miso};
         rx_valid  <= 1'b0;

         if ((state == XFER) || (state == DESEL)) div_cnt <= div_end ? 8'd0 : div_cnt + 8'd1;
         else                                     div_cnt <= '0;

         if (accept) begin
            tx_shift <= tx_data[6:0];
            spi_mosi <= tx_data[7];
            spi_cs_n <= 1'b0;
            spi_sclk <= 1'b0;
            bit_cnt  <= 3'd7;
         end else begin
            case (state)
               XFER: begin
                  if (div_end && !spi_sclk) begin
                     spi_sclk <= 1'b1;
                  end else if (div_end) begin
                     // Last cycle of a high phase: capture MISO, then drop SCK.
                     spi_sclk <= 1'b0;
                     rx_shift <= {rx_shift[5:0], miso_sync[1]};
                     if (bit_cnt == 3'd0) begin
                        rx_valid <= 1'b1;
                        rx_data  <= {rx_shift, miso_sync[1]};
                     end else begin
                        bit_cnt  <= bit_cnt - 3'd1;
                        spi_mosi <= tx_shift[6];
                        tx_shift <= {tx_shift[5:0], 1'b0};
                     end
                  end
               end
               HOLD:    if (!hold_cs) spi_cs_n <= 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: unit 0 runs CLK_DIV=4, unit 1 runs CLK_DIV=3,
// each with a byte-level slave model and a cycle-accurate timing reference.
module tb_spi_master;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   longint     cyc = 0;

   logic [7:0] tx_data  [2] = '{8'h00, 8'h00};
   logic       tx_valid [2] = '{1'b0, 1'b0};
   logic       hold_cs  [2] = '{1'b0, 1'b0};
   logic       miso     [2] = '{1'b0, 1'b0};
   logic       tx_ready [2];
   logic [7:0] rx_data  [2];
   logic       rx_valid [2];
   logic       busy     [2];
   logic       sclk     [2];
   logic       cs_n     [2];
   logic       mosi     [2];

   int n_tests = 0;
   int n_fail  = 0;

   // monitor / slave-model state, written only by the monitor process
   logic [63:0] mosi_hist [2] = '{64'd0, 64'd0};
   int          rise_cnt  [2] = '{0, 0};
   int          rxv_cnt   [2] = '{0, 0};
   int          inv_err   [2] = '{0, 0};
   int          spos      [2] = '{0, 0};
   int          sbit      [2] = '{7, 7};
   logic        prev_sclk [2] = '{1'b0, 1'b0};
   logic        prev_mosi [2] = '{1'b0, 1'b0};
   logic        prev_cs   [2] = '{1'b1, 1'b1};
   logic [7:0]  slave_bytes [2][4];

   always #20 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_unit
      spi_master #(.CLK_DIV((g == 0) ? 4 : 3)) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .tx_data  (tx_data[g]),
         .tx_valid (tx_valid[g]),
         .tx_ready (tx_ready[g]),
         .hold_cs  (hold_cs[g]),
         .rx_data  (rx_data[g]),
         .rx_valid (rx_valid[g]),
         .busy     (busy[g]),
         .spi_sclk (sclk[g]),
         .spi_cs_n (cs_n[g]),
         .spi_mosi (mosi[g]),
         .spi_miso (miso[g])
      );
   end

   // Bus monitor, protocol invariants and mode-0 slave (shifts out on SCK falling edges).
   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (sclk[u] && !prev_sclk[u]) begin
            rise_cnt[u]  = rise_cnt[u] + 1;
            mosi_hist[u] = {mosi_hist[u][62:0], mosi[u]};
         end
         if (rx_valid[u] === 1'b1) rxv_cnt[u] = rxv_cnt[u] + 1;
         if (cs_n[u] && sclk[u]) inv_err[u] = inv_err[u] + 1;
         if (sclk[u] && prev_sclk[u] && (mosi[u] !== prev_mosi[u])) inv_err[u] = inv_err[u] + 1;
         if (!busy[u] && !cs_n[u]) inv_err[u] = inv_err[u] + 1;
         if (rx_valid[u] && !busy[u]) inv_err[u] = inv_err[u] + 1;
         if (busy[u] && tx_ready[u] && cs_n[u]) inv_err[u] = inv_err[u] + 1;
         if (!cs_n[u] && prev_cs[u]) begin
            spos[u] = 0;
            sbit[u] = 7;
            miso[u] = slave_bytes[u][0][7];
         end else if (!cs_n[u] && prev_sclk[u] && !sclk[u]) begin
            if (sbit[u] == 0) begin
               spos[u] = (spos[u] + 1) % 4;
               sbit[u] = 7;
            end else begin
               sbit[u] = sbit[u] - 1;
            end
            miso[u] = slave_bytes[u][spos[u]][sbit[u]];
         end
         prev_sclk[u] = sclk[u];
         prev_mosi[u] = mosi[u];
         prev_cs[u]   = cs_n[u];
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Returns at the falling edge of the cycle in which the request is accepted.
   task automatic wait_ready(input int u, output longint t0);
      int k = 0;
      while (k < 200) begin
         @(negedge clk);
         if (tx_ready[u] === 1'b1) break;
         k++;
      end
      if (k >= 200) check("ready_timeout", 32'(tx_ready[u]), 32'd1);
      t0 = cyc;
   endtask

   // Follows one byte from T0+1 through the rx_valid cycle T0+1+16*d.
   task automatic watch_byte(input int u, input int d, input logic [7:0] exp_mosi,
                             input logic [7:0] exp_rx);
      int   r0 = rise_cnt[u];
      int   bad = 0;
      logic exp_s;
      for (int rel = 0; rel <= 16 * d; rel++) begin
         @(negedge clk);
         exp_s = (rel < 16 * d) && (((rel / d) % 2) == 1);
         if (rel == 0 && mosi[u] !== exp_mosi[7]) bad++;
         if (cs_n[u] !== 1'b0) bad++;
         if (sclk[u] !== exp_s) bad++;
         if (rel < 16 * d && rx_valid[u] !== 1'b0) bad++;
         if (rel < 16 * d && tx_ready[u] !== 1'b0) bad++;
      end
      check("byte_waveform", 32'(bad), 32'd0);
      check("rx_valid_pulse", 32'(rx_valid[u]), 32'd1);
      check("rx_data", 32'(rx_data[u]), 32'(exp_rx));
      check("sck_rising_edges", 32'(rise_cnt[u] - r0), 32'd8);
      check("mosi_bits", 32'(mosi_hist[u][7:0]), 32'(exp_mosi));
      check("hold_ready", 32'(tx_ready[u]), 32'd1);
   endtask

   task automatic desel_check(input int u, input int d);
      int bad = 0;
      for (int k = 0; k < d; k++) begin
         @(negedge clk);
         if (cs_n[u] !== 1'b1 || sclk[u] !== 1'b0 || tx_ready[u] !== 1'b0 ||
             busy[u] !== 1'b1 || rx_valid[u] !== 1'b0) bad++;
      end
      check("deselect_window", 32'(bad), 32'd0);
      @(negedge clk);
      check("idle_ready", 32'(tx_ready[u]), 32'd1);
      check("idle_busy", 32'(busy[u]), 32'd0);
      check("idle_cs_n", 32'(cs_n[u]), 32'd1);
   endtask

   // n bytes (1..4) with chip select held between them; gap = idle HOLD cycles between bytes.
   task automatic burst(input int u, input int n, input logic [31:0] txw,
                        input logic [31:0] rxw, input int gap);
      longint t0;
      int     d = (u == 0) ? 4 : 3;
      int     bad;
      for (int i = 0; i < 4; i++) slave_bytes[u][i] = rxw[8*i +: 8];
      @(posedge clk); #1;
      tx_data[u] = txw[7:0]; tx_valid[u] = 1'b1; hold_cs[u] = (n > 1);
      wait_ready(u, t0);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (i < n - 1 && gap == 0) begin
            tx_data[u] = txw[8*(i+1) +: 8]; tx_valid[u] = 1'b1; hold_cs[u] = 1'($urandom_range(1));
         end else begin
            tx_valid[u] = 1'b0; hold_cs[u] = (i < n - 1);
         end
         watch_byte(u, d, txw[8*i +: 8], rxw[8*i +: 8]);
         if (i < n - 1 && gap > 0) begin
            bad = 0;
            repeat (gap) begin
               @(negedge clk);
               if (cs_n[u] !== 1'b0 || sclk[u] !== 1'b0 || tx_ready[u] !== 1'b1 ||
                   rx_valid[u] !== 1'b0 || busy[u] !== 1'b1) bad++;
            end
            check("hold_idle", 32'(bad), 32'd0);
            @(posedge clk); #1;
            tx_data[u] = txw[8*(i+1) +: 8]; tx_valid[u] = 1'b1; hold_cs[u] = 1'($urandom_range(1));
            wait_ready(u, t0);
         end
      end
      desel_check(u, d);
   endtask

   initial begin
      longint t0;
      int     v0;
      logic [31:0] w_tx, w_rx;

      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check("rst_cs_n", 32'(cs_n[u]), 32'd1);
         check("rst_sclk", 32'(sclk[u]), 32'd0);
         check("rst_mosi", 32'(mosi[u]), 32'd0);
         check("rst_rx_data", 32'(rx_data[u]), 32'd0);
         check("rst_rx_valid", 32'(rx_valid[u]), 32'd0);
         check("rst_busy", 32'(busy[u]), 32'd0);
         check("rst_tx_ready", 32'(tx_ready[u]), 32'd0);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      check("ready_before_edge", 32'(tx_ready[0]), 32'd0);
      @(negedge clk);
      check("ready_after_edge", 32'(tx_ready[0]), 32'd1);

      // single byte 0xA5 out, 0x3C back
      burst(0, 1, 32'h0000_00A5, 32'h0000_003C, 0);

      // reset in the middle of a byte
      for (int i = 0; i < 4; i++) slave_bytes[0][i] = 8'h81;
      @(posedge clk); #1;
      tx_data[0] = 8'h96; tx_valid[0] = 1'b1; hold_cs[0] = 1'b0;
      wait_ready(0, t0);
      @(posedge clk); #1; tx_valid[0] = 1'b0;
      v0 = rxv_cnt[0];
      repeat (29) @(negedge clk);
      check("pre_reset_sclk", 32'(sclk[0]), 32'd1);
      check("pre_reset_cs_n", 32'(cs_n[0]), 32'd0);
      @(posedge clk); #1; rst_n = 1'b0;
      #1;
      check("abort_cs_n", 32'(cs_n[0]), 32'd1);
      check("abort_sclk", 32'(sclk[0]), 32'd0);
      check("abort_rx_valid", 32'(rx_valid[0]), 32'd0);
      check("abort_rx_data", 32'(rx_data[0]), 32'd0);
      check("abort_busy", 32'(busy[0]), 32'd0);
      repeat (3) @(posedge clk); #1; rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("abort_no_rx_valid", 32'(rxv_cnt[0] - v0), 32'd0);
      burst(0, 1, 32'h0000_005A, 32'h0000_00C7, 0);

      // two bytes back to back with tx_valid held and chip select kept low
      burst(0, 2, 32'h0000_3412, 32'h0000_E14B, 0);
      // request arriving while HOLD is idling, possibly together with hold_cs falling
      burst(0, 2, 32'h0000_6DB2, 32'h0000_0F90, 2);

      // request during a transfer is dropped, not queued
      for (int i = 0; i < 4; i++) slave_bytes[0][i] = 8'h69;
      @(posedge clk); #1;
      tx_data[0] = 8'h00; tx_valid[0] = 1'b1; hold_cs[0] = 1'b0;
      wait_ready(0, t0);
      @(posedge clk); #1; tx_valid[0] = 1'b0;
      v0 = rxv_cnt[0];
      fork
         watch_byte(0, 4, 8'h00, 8'h69);
         begin
            repeat (9) @(posedge clk); #1;
            tx_data[0] = 8'hFF; tx_valid[0] = 1'b1;
            @(posedge clk); #1; tx_valid[0] = 1'b0;
         end
      join
      desel_check(0, 4);
      repeat (5) @(negedge clk);
      check("no_queued_byte", 32'(cs_n[0]), 32'd1);
      check("single_rx_valid", 32'(rxv_cnt[0] - v0), 32'd1);

      // CLK_DIV=3 with MISO effectively tied high
      burst(1, 1, 32'h0000_00C3, 32'hFFFF_FFFF, 0);

      // randomized traffic on both units
      for (int k = 0; k < 8; k++) begin
         w_tx = $urandom();
         w_rx = $urandom();
         burst(int'($urandom_range(1)), 1 + int'($urandom_range(2)), w_tx, w_rx,
               int'($urandom_range(2)));
      end

      check("invariants_u0", 32'(inv_err[0]), 32'd0);
      check("invariants_u1", 32'(inv_err[1]), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #4_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1);
   end

endmodule
